// File: rtl/wb_write_queue.sv
// Write-back queue for the register file's single write port.
// Results from the load unit and the ALU are buffered in a small in-order FIFO.
// The FIFO drains one register write per cycle. Two bypass lookups let decode
// see writes that have not yet reached the register file.
module wb_write_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_wreg,
  input  logic [DW-1:0] ld_wdata,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [AW-1:0] alu_wreg,
  input  logic [DW-1:0] alu_wdata,
  output logic          regwr,
  output logic [AW-1:0] wreg,
  output logic [DW-1:0] wdata,
  input  logic [AW-1:0] rreg1,
  input  logic [AW-1:0] rreg2,
  output logic          byp1_hit,
  output logic [DW-1:0] byp1_data,
  output logic          byp2_hit,
  output logic [DW-1:0] byp2_data,
  output logic [AW-1:0] count
);

  localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] DEPTH_C  = AW'(DEPTH);
  localparam logic [AW-1:0] DEPTH_M1 = AW'(DEPTH - 1);

  // Entry storage; kept in flops because bypass must see every entry at once.
  logic [AW-1:0] wreg_mem  [DEPTH];
  logic [DW-1:0] wdata_mem [DEPTH];

  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] count_reg,  count_next;

  logic          empty;
  logic          ld_acc, alu_acc;
  logic          ld_push, alu_push;
  logic          pop;
  logic [PW-1:0] alu_slot;

  // Occupancy is the single source of truth for full/empty.
  assign empty = (count_reg == '0);

  // Readiness looks only at registered occupancy, so a same-cycle pop never
  // frees space. The ALU needs two free slots whenever a load is also offered,
  // because the load claims the first one.
  assign ld_ready  = (count_reg < DEPTH_C);
  assign alu_ready = ld_valid ? (count_reg < DEPTH_M1) : (count_reg < DEPTH_C);

  assign ld_acc  = ld_valid  & ld_ready;
  assign alu_acc = alu_valid & alu_ready;

  // Writes to r0 are consumed but never stored.
  assign ld_push  = ld_acc  & (ld_wreg  != '0);
  assign alu_push = alu_acc & (alu_wreg != '0);

  // The head is retired every cycle it is presented.
  assign pop = ~empty;

  // The load is older than the ALU beat, so the ALU lands one slot behind it.
  assign alu_slot = wr_ptr_reg + PW'(ld_push);

  // Pointer and occupancy updates; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_next = wr_ptr_reg + PW'(ld_push) + PW'(alu_push);
    rd_ptr_next = rd_ptr_reg + PW'(pop);
    count_next  = count_reg + AW'(ld_push) + AW'(alu_push) - AW'(pop);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Each slot captures the load or the ALU beat that targets it this cycle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wreg_mem[gi]  <= '0;
          wdata_mem[gi] <= '0;
        end else if (ld_push && (wr_ptr_reg == PW'(gi))) begin
          wreg_mem[gi]  <= ld_wreg;
          wdata_mem[gi] <= ld_wdata;
        end else if (alu_push && (alu_slot == PW'(gi))) begin
          wreg_mem[gi]  <= alu_wreg;
          wdata_mem[gi] <= alu_wdata;
        end
      end
    end
  endgenerate

  // Head entry drives the write port; an idle port is held at zero.
  always_comb begin
    regwr = ~empty;
    wreg  = '0;
    wdata = '0;
    if (!empty) begin
      wreg  = wreg_mem[rd_ptr_reg];
      wdata = wdata_mem[rd_ptr_reg];
    end
  end

  // Bypass search walks entries oldest to youngest so the last match, the
  // youngest, is what decode sees. The head is included; r0 never hits.
  always_comb begin
    logic [PW-1:0] idx;
    idx       = '0;
    byp1_hit  = 1'b0;
    byp1_data = '0;
    byp2_hit  = 1'b0;
    byp2_data = '0;
    for (int a = 0; a < DEPTH; a++) begin
      idx = rd_ptr_reg + PW'(a);
      if (AW'(a) < count_reg) begin
        if ((rreg1 != '0) && (wreg_mem[idx] == rreg1)) begin
          byp1_hit  = 1'b1;
          byp1_data = wdata_mem[idx];
        end
        if ((rreg2 != '0) && (wreg_mem[idx] == rreg2)) begin
          byp2_hit  = 1'b1;
          byp2_data = wdata_mem[idx];
        end
      end
    end
  end

  assign count = count_reg;

endmodule

// File: tb/tb_wb_write_queue.sv
// Scoreboard bench for wb_write_queue: stimulus pushes expected register
// writes when beats are accepted, a monitor retires them from the write port.
module tb_wb_write_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ld_valid, alu_valid;
  logic          ld_ready, alu_ready;
  logic [AW-1:0] ld_wreg, alu_wreg;
  logic [DW-1:0] ld_wdata, alu_wdata;
  logic          regwr;
  logic [AW-1:0] wreg;
  logic [DW-1:0] wdata;
  logic [AW-1:0] rreg1, rreg2;
  logic          byp1_hit, byp2_hit;
  logic [DW-1:0] byp1_data, byp2_data;
  logic [AW-1:0] count;

  wb_write_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_wreg(ld_wreg), .ld_wdata(ld_wdata),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_wreg(alu_wreg), .alu_wdata(alu_wdata),
    .regwr(regwr), .wreg(wreg), .wdata(wdata),
    .rreg1(rreg1), .rreg2(rreg2),
    .byp1_hit(byp1_hit), .byp1_data(byp1_data),
    .byp2_hit(byp2_hit), .byp2_data(byp2_data),
    .count(count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int mcount = 0;
  logic [AW+DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every register write must match the oldest expected write.
  always @(negedge clk) begin
    if (regwr === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got r%0d=%h expected no write", wreg, wdata);
      end else begin
        logic [AW+DW-1:0] e;
        e = exp_q.pop_front();
        $display("write r%0d = %h", wreg, wdata);
        chk("write_reg", 32'(wreg), 32'(e[AW+DW-1:DW]));
        chk("write_data", wdata, e[DW-1:0]);
      end
    end
  end

  // One cycle of stimulus; the model decides readiness and acceptance.
  task automatic beat(input logic lv, input logic [AW-1:0] lr, input logic [DW-1:0] ld,
                      input logic av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                      output logic aa);
    logic exp_lr, exp_ar;
    int pushes;
    ld_valid = lv; ld_wreg = lr; ld_wdata = ld;
    alu_valid = av; alu_wreg = ar; alu_wdata = ad;
    #1;
    exp_lr = (mcount < DEPTH);
    exp_ar = lv ? (mcount <= DEPTH - 2) : (mcount < DEPTH);
    chk("ld_ready", 32'(ld_ready), 32'(exp_lr));
    chk("alu_ready", 32'(alu_ready), 32'(exp_ar));
    @(posedge clk);
    pushes = 0;
    if (lv && exp_lr && lr != 0) begin exp_q.push_back({lr, ld}); pushes++; end
    if (av && exp_ar && ar != 0) begin exp_q.push_back({ar, ad}); pushes++; end
    mcount = mcount + pushes - ((mcount > 0) ? 1 : 0);
    aa = av && exp_ar;
    #1;
    ld_valid = 1'b0; alu_valid = 1'b0;
    chk("count", 32'(count), 32'(mcount));
  endtask

  task automatic idle(input int n);
    ld_valid = 1'b0; alu_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      if (mcount > 0) mcount--;
      #1;
      chk("count_idle", 32'(count), 32'(mcount));
    end
  endtask

  initial begin
    logic aa;
    int i, cyc;
    rst_n = 1'b0;
    ld_valid = 0; ld_wreg = 0; ld_wdata = 0;
    alu_valid = 0; alu_wreg = 0; alu_wdata = 0;
    rreg1 = 0; rreg2 = 0;
    #3;
    chk("rst_regwr", 32'(regwr), 32'd0);
    chk("rst_wreg", 32'(wreg), 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_byp1_hit", 32'(byp1_hit), 32'd0);
    chk("rst_byp1_data", byp1_data, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    // Single ALU beat: one write of r5 on the following cycle.
    beat(0, 0, 0, 1, 5, 32'h1234, aa);
    rreg1 = 5; #1;
    chk("byp_r5_hit", 32'(byp1_hit), 32'd1);
    chk("byp_r5_data", byp1_data, 32'h1234);
    idle(3);

    // Same-cycle load and ALU to r8: load first, youngest wins the bypass.
    beat(1, 8, 32'hA, 1, 8, 32'hB, aa);
    rreg1 = 8; rreg2 = 3; #1;
    chk("byp_r8_hit", 32'(byp1_hit), 32'd1);
    chk("byp_r8_data", byp1_data, 32'hB);
    chk("byp_r3_hit", 32'(byp2_hit), 32'd0);
    chk("byp_r3_data", byp2_data, 32'd0);
    idle(1);
    chk("byp_r8_data_2", byp1_data, 32'hB);
    idle(2);

    // Fill: occupancy 3 admits the load but not the ALU when both are offered.
    beat(1, 1, 32'h101, 1, 2, 32'h102, aa);
    beat(1, 3, 32'h103, 1, 4, 32'h104, aa);
    beat(1, 5, 32'h105, 1, 6, 32'h106, aa);
    chk("alu_blocked", 32'(aa), 32'd0);
    beat(0, 0, 0, 1, 6, 32'h106, aa);
    idle(5);

    // r0 writes are consumed silently and never bypass.
    beat(0, 0, 0, 1, 0, 32'hFFFF, aa);
    chk("r0_accepted", 32'(aa), 32'd1);
    rreg1 = 0; #1;
    chk("byp_r0_hit", 32'(byp1_hit), 32'd0);
    beat(1, 0, 32'h55, 1, 7, 32'h77, aa);
    rreg1 = 0; rreg2 = 7; #1;
    chk("byp_r0_hit_2", 32'(byp1_hit), 32'd0);
    chk("byp_r7_data", byp2_data, 32'h77);
    idle(3);

    // Reset mid-drain with three entries pending: everything is dropped.
    beat(1, 11, 32'h111, 1, 12, 32'h222, aa);
    beat(1, 13, 32'h333, 1, 14, 32'h444, aa);
    rreg1 = 13; #1;
    rst_n = 1'b0; #1;
    exp_q.delete();
    mcount = 0;
    chk("midrst_regwr", 32'(regwr), 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_byp", 32'(byp1_hit), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(4);

    // Wrap: ten ALU beats with intermittent loads, retried until accepted.
    i = 1; cyc = 0;
    while (i <= 10 && cyc < 100) begin
      beat((cyc % 3) == 0, AW'(16 + (cyc % 8)), 32'hD000 + cyc,
           1, AW'(i), 32'hA000 + i, aa);
      if (aa) i++;
      cyc++;
    end
    chk("wrap_done", 32'(i), 32'd11);
    idle(6);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
